// File: rtl/ft601_pkg.sv
// ft601_pkg: shared widths and error-bit indices for the FT601 device-side responder
package ft601_pkg;
  localparam int FT601_DATA_W = 32;
  localparam int FT601_BE_W = 4;
  localparam int FT601_ERR_W = 4;
  localparam int ERR_WR_FULL = 0;
  localparam int ERR_RD_EMPTY = 1;
  localparam int ERR_BUS_CONTENTION = 2;
  localparam int ERR_RD_NO_OE = 3;
endpackage

// File: rtl/ft601_resp_fifo.sv
// ft601_resp_fifo: first-word-fall-through FIFO with synchronous clear and occupancy count
module ft601_resp_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  // Guard against overflow/underflow so the caller cannot corrupt the pointers
  always_comb begin
    do_push = push & (count != CW'(DEPTH));
    do_pop = pop & (count != '0);
    dout = mem[rp];
  end
  // Pointers and count; clear wins over any same-cycle push or pop
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (clr) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop) rp <= rp + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  // Storage carries no reset; only slots below count are ever observed
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wp] <= din;
  end
endmodule

// File: rtl/ft601_responder.sv
// ft601_responder: FT601 245-sync-FIFO device model with PC-side ready/valid ports
module ft601_responder
  import ft601_pkg::*;
#(
  parameter int RX_DEPTH = 16,
  parameter int TX_DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_l,
  input  logic                      usb_rst_l,
  input  logic                      usb_wren_l,
  input  logic                      usb_rden_l,
  input  logic                      usb_outen_l,
  input  logic [FT601_DATA_W-1:0]   usb_data_from_host,
  input  logic [FT601_BE_W-1:0]     be_from_host,
  output logic                      usb_tx_full,
  output logic                      usb_rx_empty,
  output logic [FT601_DATA_W-1:0]   usb_data_to_host,
  output logic [FT601_BE_W-1:0]     be_to_host,
  output logic                      data_oe,
  input  logic [FT601_DATA_W-1:0]   pc_wr_data,
  input  logic                      pc_wr_valid,
  output logic                      pc_wr_ready,
  output logic [FT601_DATA_W-1:0]   pc_rd_data,
  output logic [FT601_BE_W-1:0]     pc_rd_be,
  output logic                      pc_rd_valid,
  input  logic                      pc_rd_ready,
  input  logic                      tx_stall,
  output logic [FT601_ERR_W-1:0]    err
);
  localparam int RCW = $clog2(RX_DEPTH) + 1;
  localparam int TCW = $clog2(TX_DEPTH) + 1;
  logic [RCW-1:0] rx_count;
  logic [TCW-1:0] tx_count;
  logic [FT601_DATA_W-1:0] rx_head;
  logic [FT601_BE_W+FT601_DATA_W-1:0] tx_head;
  logic live, clr, wr, rd, oe, rx_ok, rx_push, rx_pop, tx_push, tx_pop;
  logic [FT601_ERR_W-1:0] err_set;
  // Strobe decode, flags from registered counts, and protocol-violation detection
  always_comb begin
    live = usb_rst_l;
    clr = ~usb_rst_l;
    wr = ~usb_wren_l;
    rd = ~usb_rden_l;
    oe = ~usb_outen_l;
    usb_rx_empty = ~live | (rx_count == '0);
    usb_tx_full = ~live | tx_stall | (tx_count == TCW'(TX_DEPTH));
    data_oe = oe;
    rx_ok = oe & ~usb_rx_empty;
    usb_data_to_host = rx_ok ? rx_head : '0;
    be_to_host = rx_ok ? {FT601_BE_W{1'b1}} : '0;
    pc_wr_ready = live & (rx_count != RCW'(RX_DEPTH));
    pc_rd_valid = live & (tx_count != '0);
    pc_rd_data = tx_head[FT601_DATA_W-1:0];
    pc_rd_be = tx_head[FT601_BE_W+FT601_DATA_W-1:FT601_DATA_W];
    rx_push = pc_wr_valid & pc_wr_ready;
    tx_pop = pc_rd_valid & pc_rd_ready;
    tx_push = live & wr & ~oe & ~usb_tx_full;
    rx_pop = live & rd & rx_ok;
    err_set = '0;
    err_set[ERR_WR_FULL] = live & wr & ~oe & usb_tx_full;
    err_set[ERR_RD_EMPTY] = live & rd & oe & usb_rx_empty;
    err_set[ERR_BUS_CONTENTION] = live & wr & oe;
    err_set[ERR_RD_NO_OE] = live & rd & ~oe;
  end
  // Sticky error bits, cleared only by the board-level reset
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) err <= '0;
    else err <= err | err_set;
  end
  ft601_resp_fifo #(.WIDTH(FT601_DATA_W), .DEPTH(RX_DEPTH)) u_rx (
    .clk(clk),
    .rst_l(rst_l),
    .clr(clr),
    .push(rx_push),
    .din(pc_wr_data),
    .pop(rx_pop),
    .dout(rx_head),
    .count(rx_count)
  );
  ft601_resp_fifo #(.WIDTH(FT601_BE_W + FT601_DATA_W), .DEPTH(TX_DEPTH)) u_tx (
    .clk(clk),
    .rst_l(rst_l),
    .clr(clr),
    .push(tx_push),
    .din({be_from_host, usb_data_from_host}),
    .pop(tx_pop),
    .dout(tx_head),
    .count(tx_count)
  );
endmodule

// File: tb/tb_ft601_responder.sv
// tb_ft601_responder: table-driven directed check of the FT601 responder
module tb_ft601_responder;
  typedef struct {
    logic u, w, r, o;
    logic [31:0] hd;
    logic [3:0] hb;
    logic pwv;
    logic [31:0] pwd;
    logic prr;
    logic rxe, txf;
    logic [31:0] dth;
    logic [3:0] be;
    logic oe, pwr, prv;
    logic [31:0] prd;
    logic [3:0] pbe;
    logic [3:0] err;
  } vec_t;
  logic clk = 0, rst_l = 0, usb_rst_l = 1, usb_wren_l = 1, usb_rden_l = 1, usb_outen_l = 1;
  logic [31:0] usb_data_from_host = 0, pc_wr_data = 0;
  logic [3:0] be_from_host = 4'hF;
  logic pc_wr_valid = 0, pc_rd_ready = 0, tx_stall = 0;
  logic usb_tx_full, usb_rx_empty, data_oe, pc_wr_ready, pc_rd_valid;
  logic [31:0] usb_data_to_host, pc_rd_data;
  logic [3:0] be_to_host, pc_rd_be, err;
  int n_cmp = 0, n_bad = 0;
  vec_t tbl[$];
  ft601_responder #(.RX_DEPTH(4), .TX_DEPTH(4)) dut (
    .clk(clk), .rst_l(rst_l), .usb_rst_l(usb_rst_l),
    .usb_wren_l(usb_wren_l), .usb_rden_l(usb_rden_l), .usb_outen_l(usb_outen_l),
    .usb_data_from_host(usb_data_from_host), .be_from_host(be_from_host),
    .usb_tx_full(usb_tx_full), .usb_rx_empty(usb_rx_empty),
    .usb_data_to_host(usb_data_to_host), .be_to_host(be_to_host), .data_oe(data_oe),
    .pc_wr_data(pc_wr_data), .pc_wr_valid(pc_wr_valid), .pc_wr_ready(pc_wr_ready),
    .pc_rd_data(pc_rd_data), .pc_rd_be(pc_rd_be), .pc_rd_valid(pc_rd_valid),
    .pc_rd_ready(pc_rd_ready), .tx_stall(tx_stall), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic add(input logic u, w, r, o, input logic [31:0] hd, input logic [3:0] hb,
                     input logic pwv, input logic [31:0] pwd, input logic prr,
                     input logic rxe, txf, input logic [31:0] dth, input logic [3:0] be,
                     input logic oe, pwr, prv, input logic [31:0] prd, input logic [3:0] pbe,
                     input logic [3:0] e);
    vec_t v;
    v.u = u; v.w = w; v.r = r; v.o = o; v.hd = hd; v.hb = hb; v.pwv = pwv; v.pwd = pwd; v.prr = prr;
    v.rxe = rxe; v.txf = txf; v.dth = dth; v.be = be; v.oe = oe; v.pwr = pwr; v.prv = prv;
    v.prd = prd; v.pbe = pbe; v.err = e;
    tbl.push_back(v);
  endtask
  task automatic drive(input vec_t v);
    usb_rst_l = v.u; usb_wren_l = v.w; usb_rden_l = v.r; usb_outen_l = v.o;
    usb_data_from_host = v.hd; be_from_host = v.hb;
    pc_wr_valid = v.pwv; pc_wr_data = v.pwd; pc_rd_ready = v.prr;
  endtask
  initial begin
    // RX drain: PC pushes four words, controller reads them back-to-back
    add(1,1,1,1, 0,4'hF, 1,32'h11111111, 0,  1,0, 0,0, 0,1,0, 0,0, 4'h0);
    add(1,1,1,1, 0,4'hF, 1,32'h22222222, 0,  0,0, 0,0, 0,1,0, 0,0, 4'h0);
    add(1,1,1,1, 0,4'hF, 1,32'h33333333, 0,  0,0, 0,0, 0,1,0, 0,0, 4'h0);
    add(1,1,1,1, 0,4'hF, 1,32'h44444444, 0,  0,0, 0,0, 0,1,0, 0,0, 4'h0);
    add(1,1,1,0, 0,4'hF, 0,0, 0,  0,0, 32'h11111111,4'hF, 1,0,0, 0,0, 4'h0);
    add(1,1,0,0, 0,4'hF, 0,0, 0,  0,0, 32'h11111111,4'hF, 1,0,0, 0,0, 4'h0);
    add(1,1,0,0, 0,4'hF, 0,0, 0,  0,0, 32'h22222222,4'hF, 1,1,0, 0,0, 4'h0);
    add(1,1,0,0, 0,4'hF, 0,0, 0,  0,0, 32'h33333333,4'hF, 1,1,0, 0,0, 4'h0);
    add(1,1,0,0, 0,4'hF, 0,0, 0,  0,0, 32'h44444444,4'hF, 1,1,0, 0,0, 4'h0);
    add(1,1,1,0, 0,4'hF, 0,0, 0,  1,0, 0,0, 1,1,0, 0,0, 4'h0);
    // Simultaneous RX push/pop at count 1
    add(1,1,1,1, 0,4'hF, 1,32'h55, 0,  1,0, 0,0, 0,1,0, 0,0, 4'h0);
    add(1,1,0,0, 0,4'hF, 1,32'h66, 0,  0,0, 32'h55,4'hF, 1,1,0, 0,0, 4'h0);
    add(1,1,1,0, 0,4'hF, 0,0, 0,  0,0, 32'h66,4'hF, 1,1,0, 0,0, 4'h0);
    add(1,1,0,0, 0,4'hF, 0,0, 0,  0,0, 32'h66,4'hF, 1,1,0, 0,0, 4'h0);
    add(1,1,1,0, 0,4'hF, 0,0, 0,  1,0, 0,0, 1,1,0, 0,0, 4'h0);
    // Fill RX, then push/pop at full depth: the push is refused while full
    add(1,1,1,1, 0,4'hF, 1,32'h70, 0,  1,0, 0,0, 0,1,0, 0,0, 4'h0);
    add(1,1,1,1, 0,4'hF, 1,32'h71, 0,  0,0, 0,0, 0,1,0, 0,0, 4'h0);
    add(1,1,1,1, 0,4'hF, 1,32'h72, 0,  0,0, 0,0, 0,1,0, 0,0, 4'h0);
    add(1,1,1,1, 0,4'hF, 1,32'h73, 0,  0,0, 0,0, 0,1,0, 0,0, 4'h0);
    add(1,1,0,0, 0,4'hF, 1,32'h74, 0,  0,0, 32'h70,4'hF, 1,0,0, 0,0, 4'h0);
    add(1,1,0,0, 0,4'hF, 1,32'h75, 0,  0,0, 32'h71,4'hF, 1,1,0, 0,0, 4'h0);
    add(1,1,0,0, 0,4'hF, 0,0, 0,  0,0, 32'h72,4'hF, 1,1,0, 0,0, 4'h0);
    add(1,1,0,0, 0,4'hF, 0,0, 0,  0,0, 32'h73,4'hF, 1,1,0, 0,0, 4'h0);
    add(1,1,0,0, 0,4'hF, 0,0, 0,  0,0, 32'h75,4'hF, 1,1,0, 0,0, 4'h0);
    // Read on empty RX -> err[1]
    add(1,1,0,0, 0,4'hF, 0,0, 0,  1,0, 0,0, 1,1,0, 0,0, 4'h0);
    add(1,1,1,1, 0,4'hF, 0,0, 0,  1,0, 0,0, 0,1,0, 0,0, 4'h2);
    // TX fill and overflow, second word carries BE=3
    add(1,0,1,1, 32'hA0,4'hF, 0,0, 0,  1,0, 0,0, 0,1,0, 0,0, 4'h2);
    add(1,0,1,1, 32'hA1,4'h3, 0,0, 0,  1,0, 0,0, 0,1,1, 32'hA0,4'hF, 4'h2);
    add(1,0,1,1, 32'hA2,4'hF, 0,0, 0,  1,0, 0,0, 0,1,1, 32'hA0,4'hF, 4'h2);
    add(1,0,1,1, 32'hA3,4'hF, 0,0, 0,  1,0, 0,0, 0,1,1, 32'hA0,4'hF, 4'h2);
    add(1,0,1,1, 32'hA4,4'hF, 0,0, 0,  1,1, 0,0, 0,1,1, 32'hA0,4'hF, 4'h2);
    add(1,1,1,1, 0,4'hF, 0,0, 1,  1,1, 0,0, 0,1,1, 32'hA0,4'hF, 4'h3);
    add(1,0,1,1, 32'hB0,4'hF, 0,0, 1,  1,0, 0,0, 0,1,1, 32'hA1,4'h3, 4'h3);
    add(1,1,1,1, 0,4'hF, 0,0, 1,  1,0, 0,0, 0,1,1, 32'hA2,4'hF, 4'h3);
    add(1,1,1,1, 0,4'hF, 0,0, 1,  1,0, 0,0, 0,1,1, 32'hA3,4'hF, 4'h3);
    add(1,1,1,1, 0,4'hF, 0,0, 1,  1,0, 0,0, 0,1,1, 32'hB0,4'hF, 4'h3);
    add(1,1,1,1, 0,4'hF, 0,0, 0,  1,0, 0,0, 0,1,0, 0,0, 4'h3);
    // Contention and read without output enable
    add(1,0,1,0, 32'hC0,4'hF, 0,0, 0,  1,0, 0,0, 1,1,0, 0,0, 4'h3);
    add(1,1,1,1, 0,4'hF, 0,0, 0,  1,0, 0,0, 0,1,0, 0,0, 4'h7);
    add(1,1,1,1, 0,4'hF, 1,32'h88, 0,  1,0, 0,0, 0,1,0, 0,0, 4'h7);
    add(1,1,0,1, 0,4'hF, 0,0, 0,  0,0, 0,0, 0,1,0, 0,0, 4'h7);
    add(1,1,1,0, 0,4'hF, 0,0, 0,  0,0, 32'h88,4'hF, 1,1,0, 0,0, 4'hF);
    // Device reset with RX=3, TX=2; strobes during it are ignored
    add(1,0,1,1, 32'hD0,4'hF, 1,32'h89, 0,  0,0, 0,0, 0,1,0, 0,0, 4'hF);
    add(1,0,1,1, 32'hD1,4'hF, 1,32'h8A, 0,  0,0, 0,0, 0,1,1, 32'hD0,4'hF, 4'hF);
    add(0,0,0,0, 32'hE0,4'hF, 1,32'h8B, 1,  1,1, 0,0, 1,0,0, 0,0, 4'hF);
    add(1,1,1,1, 0,4'hF, 0,0, 0,  1,0, 0,0, 0,1,0, 0,0, 4'hF);
    add(1,1,1,0, 0,4'hF, 0,0, 0,  1,0, 0,0, 1,1,0, 0,0, 4'hF);
    #12;
    chk("rst_rxe", 32'(usb_rx_empty), 1);
    chk("rst_txf", 32'(usb_tx_full), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_pwr", 32'(pc_wr_ready), 1);
    chk("rst_prv", 32'(pc_rd_valid), 0);
    chk("rst_dth", usb_data_to_host, 0);
    @(negedge clk) rst_l = 1;
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk($sformatf("r%0d_rxe", i), 32'(usb_rx_empty), 32'(tbl[i].rxe));
      chk($sformatf("r%0d_txf", i), 32'(usb_tx_full), 32'(tbl[i].txf));
      chk($sformatf("r%0d_dth", i), usb_data_to_host, tbl[i].dth);
      chk($sformatf("r%0d_be", i), 32'(be_to_host), 32'(tbl[i].be));
      chk($sformatf("r%0d_oe", i), 32'(data_oe), 32'(tbl[i].oe));
      chk($sformatf("r%0d_pwr", i), 32'(pc_wr_ready), 32'(tbl[i].pwr));
      chk($sformatf("r%0d_prv", i), 32'(pc_rd_valid), 32'(tbl[i].prv));
      chk($sformatf("r%0d_err", i), 32'(err), 32'(tbl[i].err));
      if (tbl[i].prv) begin
        chk($sformatf("r%0d_prd", i), pc_rd_data, tbl[i].prd);
        chk($sformatf("r%0d_pbe", i), 32'(pc_rd_be), 32'(tbl[i].pbe));
      end
    end
    // tx_stall forces full combinationally on an empty TX FIFO
    @(negedge clk);
    usb_outen_l = 1; tx_stall = 1;
    #1 chk("stall_on", 32'(usb_tx_full), 1);
    chk("stall_prv", 32'(pc_rd_valid), 0);
    tx_stall = 0;
    #1 chk("stall_off", 32'(usb_tx_full), 0);
    // Asynchronous rst_l clears err mid-cycle and empties RX immediately
    @(negedge clk) begin pc_wr_valid = 1; pc_wr_data = 32'h99; end
    @(negedge clk) pc_wr_valid = 0;
    #1 chk("pre_rst_rxe", 32'(usb_rx_empty), 0);
    usb_outen_l = 0;
    #1 chk("pre_rst_dth", usb_data_to_host, 32'h99);
    rst_l = 0; tx_stall = 1;
    #1 chk("arst_err", 32'(err), 0);
    chk("arst_rxe", 32'(usb_rx_empty), 1);
    chk("arst_dth", usb_data_to_host, 0);
    chk("arst_be", 32'(be_to_host), 0);
    chk("arst_oe", 32'(data_oe), 1);
    chk("arst_txf", 32'(usb_tx_full), 1);
    chk("arst_pwr", 32'(pc_wr_ready), 1);
    chk("arst_prv", 32'(pc_rd_valid), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
